// File: rtl/baud_pkg.sv
// baud_pkg: rate select encoding, preset baud table and divisor arithmetic shared by the UART blocks.
package baud_pkg;
  typedef enum logic [2:0] {
    BAUD_2400, BAUD_4800, BAUD_9600, BAUD_19200,
    BAUD_38400, BAUD_57600, BAUD_115200, BAUD_CUSTOM
  } baud_sel_e;
  localparam int unsigned BAUD_RATE [7] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200};
  // Fixed-point clocks per oversample tick, rounded to nearest, with frac_w fraction bits.
  function automatic longint unsigned divisor(input int unsigned clk_hz, input int unsigned baud,
                                              input int unsigned os, input int unsigned frac_w);
    longint unsigned num, den;
    num = 64'(clk_hz) << frac_w;
    den = 64'(baud) * 64'(os);
    return (num + den / 64'd2) / den;
  endfunction
endpackage

// File: rtl/frac_divider.sv
// frac_divider: fractional clock divider producing a raw one-cycle tick every int or int+1 cycles.
module frac_divider #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d, int_eff, limit;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] sum;
  // The accumulator carry stretches the current period by one cycle.
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, div_frac};
    int_eff = div_int < DIV_W'(2) ? DIV_W'(2) : div_int;
    limit = int_eff - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
    tick = enable && !restart && cnt_q == limit;
    cnt_d = (restart || tick) ? '0 : enable ? cnt_q + DIV_W'(1) : cnt_q;
    acc_d = restart ? '0 : tick ? sum[FRAC_W-1:0] : acc_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: selectable-rate oversample, mid-bit and bit-boundary strobe generator for the UART.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [2:0]                    baud_sel,
  input  logic [DIV_W+FRAC_W-1:0]       custom_div,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
  localparam int unsigned DW = DIV_W + FRAC_W;
  localparam int unsigned PW = $clog2(OVERSAMPLE);
  logic [2:0] sel_q, sel_d;
  logic [DW-1:0] div_q, div_d, cust_q, cust_d;
  logic [PW-1:0] phase_q, phase_d;
  logic os_q, os_d, mid_q, mid_d, bit_q, bit_d;
  logic sel_chg, cust_load, restart, tick;
  logic [DW-1:0] preset [8];
  for (genvar i = 0; i < 7; i++) begin : g_preset
    assign preset[i] = DW'(divisor(CLK_HZ, BAUD_RATE[i], OVERSAMPLE, FRAC_W));
  end
  assign preset[7] = cust_q;
  // A custom load takes priority over a simultaneous sel change so the fresh divisor is used.
  always_comb begin
    sel_chg = baud_sel != sel_q;
    cust_load = div_load && baud_sel == BAUD_CUSTOM;
    restart = resync || sel_chg || cust_load;
    sel_d = baud_sel;
    cust_d = div_load ? custom_div : cust_q;
    div_d = cust_load ? custom_div : sel_chg ? preset[baud_sel] : div_q;
    phase_d = restart ? '0 : !tick ? phase_q : phase_q == PW'(OVERSAMPLE - 1) ? '0 : phase_q + PW'(1);
    os_d = tick;
    mid_d = tick && phase_q == PW'(OVERSAMPLE / 2 - 1);
    bit_d = tick && phase_q == PW'(OVERSAMPLE - 1);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel_q <= BAUD_9600;
      div_q <= preset[BAUD_9600];
      cust_q <= preset[BAUD_9600];
      phase_q <= '0;
      os_q <= 1'b0;
      mid_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      div_q <= div_d;
      cust_q <= cust_d;
      phase_q <= phase_d;
      os_q <= os_d;
      mid_q <= mid_d;
      bit_q <= bit_d;
    end
  end
  frac_divider #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .restart  (restart),
    .div_int  (div_q[DW-1:FRAC_W]),
    .div_frac (div_q[FRAC_W-1:0]),
    .tick     (tick)
  );
  assign os_tick = os_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;
  assign os_phase = phase_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scenario tasks checking tick timing against an arithmetic period/phase model.
module tb_baud_tick_gen;
  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b1, div_load = 1'b0, resync = 1'b0;
  logic [2:0] baud_sel = 3'd2;
  logic [19:0] custom_div = '0;
  logic os_tick, mid_tick, bit_tick;
  logic [3:0] os_phase;
  int total = 0, passed = 0;

  baud_tick_gen dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .baud_sel(baud_sel),
    .custom_div(custom_div), .div_load(div_load), .resync(resync),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .os_phase(os_phase)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int di, input int df, input logic rs);
    custom_div = {16'(di), 4'(df)};
    div_load = 1'b1;
    resync = rs;
    step();
    div_load = 1'b0;
    resync = 1'b0;
  endtask

  task automatic wait_phase(input int p, output bit ok);
    int n = 0;
    ok = 0;
    while (n < 20000 && !ok) begin
      step();
      n++;
      ok = os_tick === 1'b1 && int'(os_phase) == p;
    end
  endtask

  // Model: after a restart, tick k ends a long period iff floor((k+1)f/16) > floor(kf/16).
  task automatic test_rate(input string name, input int di, input int df, input int n, input int p0,
                           output int tot, output int bits);
    int ie, per, expp, stray, ph;
    ie = di < 2 ? 2 : di;
    tot = 0;
    bits = 0;
    stray = 0;
    for (int k = 0; k < n; k++) begin
      per = 0;
      do begin
        step();
        per++;
        if ((mid_tick || bit_tick) && !os_tick) stray++;
      end while (os_tick !== 1'b1 && per < 4000);
      expp = ie + ((k + 1) * df) / 16 - (k * df) / 16;
      ph = (p0 + k) % 16;
      total++;
      if (per !== expp) $display("FAIL %s period[%0d]: got %0d want %0d", name, k, per, expp);
      else passed++;
      total++;
      if (int'(os_phase) !== (ph + 1) % 16)
        $display("FAIL %s os_phase[%0d]: got %0d want %0d", name, k, os_phase, (ph + 1) % 16);
      else passed++;
      total++;
      if (mid_tick !== (ph == 7)) $display("FAIL %s mid_tick[%0d]: got %b want %b", name, k, mid_tick, ph == 7);
      else passed++;
      total++;
      if (bit_tick !== (ph == 15)) $display("FAIL %s bit_tick[%0d]: got %b want %b", name, k, bit_tick, ph == 15);
      else passed++;
      tot += per;
      bits += int'(bit_tick);
    end
    total++;
    if (stray !== 0) $display("FAIL %s stray mid/bit: got %0d want 0", name, stray);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    baud_sel = 3'd2;
    enable = 1'b1;
    step();
    step();
    total++;
    if (os_tick !== 1'b0) $display("FAIL reset os_tick: got %b want 0", os_tick); else passed++;
    total++;
    if (mid_tick !== 1'b0) $display("FAIL reset mid_tick: got %b want 0", mid_tick); else passed++;
    total++;
    if (bit_tick !== 1'b0) $display("FAIL reset bit_tick: got %b want 0", bit_tick); else passed++;
    total++;
    if (os_phase !== 4'd0) $display("FAIL reset os_phase: got %0d want 0", os_phase); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_9600();
    int tot, bits;
    test_rate("r9600", 325, 8, 16, 0, tot, bits);
    total++;
    if (tot !== 5208) $display("FAIL r9600 bit cycles: got %0d want 5208", tot); else passed++;
    total++;
    if (bits !== 1) $display("FAIL r9600 bit_ticks: got %0d want 1", bits); else passed++;
  endtask

  task automatic test_sel_change();
    int tot, bits;
    bit ok;
    wait_phase(9, ok);
    total++;
    if (!ok) $display("FAIL selchg reach phase 9: got timeout want phase 9"); else passed++;
    repeat ($urandom_range(1, 200)) step();
    baud_sel = 3'd6;
    custom_div = {16'd6, 4'd0};
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (os_phase !== 4'd0) $display("FAIL selchg restart os_phase: got %0d want 0", os_phase); else passed++;
    total++;
    if (os_tick !== 1'b0) $display("FAIL selchg restart os_tick: got %b want 0", os_tick); else passed++;
    test_rate("r115200", 27, 2, 16, 0, tot, bits);
    total++;
    if (tot !== 434) $display("FAIL r115200 bit cycles: got %0d want 434", tot); else passed++;
    total++;
    if (bits !== 1) $display("FAIL r115200 bit_ticks: got %0d want 1", bits); else passed++;
    baud_sel = 3'd7;
    step();
    test_rate("cust_reg", 6, 0, 8, 0, tot, bits);
  endtask

  task automatic test_custom();
    int tot, bits;
    load(4, 0, 1'b0);
    test_rate("div4", 4, 0, 32, 0, tot, bits);
    total++;
    if (tot !== 128) $display("FAIL div4 cycles: got %0d want 128", tot); else passed++;
    total++;
    if (bits !== 2) $display("FAIL div4 bit_ticks: got %0d want 2", bits); else passed++;
  endtask

  task automatic test_frac();
    int tot, bits, di, df;
    load(4, 8, 1'b0);
    test_rate("div4_8", 4, 8, 16, 0, tot, bits);
    load(1, 0, 1'b0);
    test_rate("clamp1", 1, 0, 8, 0, tot, bits);
    load(0, 5, 1'b0);
    test_rate("clamp0_5", 0, 5, 16, 0, tot, bits);
    repeat (4) begin
      di = int'($urandom_range(0, 24));
      df = int'($urandom_range(0, 15));
      load(di, df, 1'b0);
      test_rate("rand_div", di, df, 16, 0, tot, bits);
    end
  endtask

  task automatic test_resync();
    int tot, bits, di, df;
    bit ok;
    load(5, 0, 1'b0);
    wait_phase(9, ok);
    total++;
    if (!ok) $display("FAIL resync reach phase 9: got timeout want phase 9"); else passed++;
    repeat (4) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    total++;
    if (os_tick !== 1'b0) $display("FAIL resync suppress os_tick: got %b want 0", os_tick); else passed++;
    total++;
    if (os_phase !== 4'd0) $display("FAIL resync os_phase: got %0d want 0", os_phase); else passed++;
    test_rate("post_resync", 5, 0, 4, 0, tot, bits);
    di = int'($urandom_range(3, 12));
    df = int'($urandom_range(0, 15));
    load(di, df, 1'b0);
    repeat ($urandom_range(0, 40)) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    test_rate("rand_resync", di, df, 16, 0, tot, bits);
  endtask

  task automatic test_enable();
    int bad, per;
    bit ok;
    load(6, 0, 1'b0);
    wait_phase(5, ok);
    total++;
    if (!ok) $display("FAIL enable reach phase 5: got timeout want phase 5"); else passed++;
    step();
    step();
    enable = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (os_tick !== 1'b0 || os_phase !== 4'd5) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL enable hold: got %0d bad cycles want 0", bad); else passed++;
    enable = 1'b1;
    per = 0;
    do begin
      step();
      per++;
    end while (os_tick !== 1'b1 && per < 4000);
    total++;
    if (per !== 4) $display("FAIL enable resume cycles: got %0d want 4", per); else passed++;
    total++;
    if (os_phase !== 4'd6) $display("FAIL enable resume os_phase: got %0d want 6", os_phase); else passed++;
  endtask

  task automatic test_back_to_back();
    int tot, bits;
    load(9, 0, 1'b0);
    repeat (13) step();
    load(3, 0, 1'b1);
    total++;
    if (os_phase !== 4'd0) $display("FAIL sim restart os_phase: got %0d want 0", os_phase); else passed++;
    test_rate("sim_load", 3, 0, 16, 0, tot, bits);
  endtask

  task automatic test_reset_mid();
    int tot, bits;
    load(7, 0, 1'b0);
    repeat (30) step();
    reset_n = 1'b0;
    baud_sel = 3'd2;
    step();
    total++;
    if (os_tick !== 1'b0) $display("FAIL midreset os_tick: got %b want 0", os_tick); else passed++;
    total++;
    if (mid_tick !== 1'b0) $display("FAIL midreset mid_tick: got %b want 0", mid_tick); else passed++;
    total++;
    if (bit_tick !== 1'b0) $display("FAIL midreset bit_tick: got %b want 0", bit_tick); else passed++;
    total++;
    if (os_phase !== 4'd0) $display("FAIL midreset os_phase: got %0d want 0", os_phase); else passed++;
    reset_n = 1'b1;
    test_rate("after_reset", 325, 8, 4, 0, tot, bits);
    baud_sel = 3'd7;
    step();
    test_rate("cust_after_reset", 325, 8, 2, 0, tot, bits);
  endtask

  initial begin
    test_reset();
    test_9600();
    test_sel_change();
    test_custom();
    test_frac();
    test_resync();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, fractional-divide baud tick generator serving the UART Tx and Rx units. It produces single-cycle oversample, mid-bit and bit-boundary strobes instead of a toggled divided clock, so every consumer stays on the single system clock. It provides eight runtime-selectable rates, including one programmable custom divisor, and a resync input the Rx front end pulses on start-bit detection to realign bit phase.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency used to build the preset divisor table
- OVERSAMPLE, 16, oversample ticks per bit; must be even and ≥4
- DIV_W, 16, integer-part width of the divisor
- FRAC_W, 4, fractional-part width of the divisor

Ports:
- clock  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  when low, counters hold and no ticks are issued
- baud_sel  in  3  rate select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=custom
- custom_div  in  DIV_W+FRAC_W  custom divisor {int, frac}, in clocks per oversample tick
- div_load  in  1  one-cycle strobe that latches custom_div into the custom register
- resync  in  1  one-cycle strobe that restarts bit phase
- os_tick  out  1  one-cycle oversample strobe
- mid_tick  out  1  one-cycle strobe at bit centre (Rx sample point)
- bit_tick  out  1  one-cycle strobe at bit boundary (Tx shift point)
- os_phase  out  $clog2(OVERSAMPLE)  current oversample index within the bit

## Operation
- Preset divisor D = round(CLK_HZ·2^FRAC_W / (baud·OVERSAMPLE)), computed at elaboration. Example at 50 MHz: 9600 → int 325, frac 8; 115200 → int 27, frac 2.
- Active divisor register: reloaded from the table, or from the custom register when sel=7, whenever registered baud_sel differs from baud_sel. The reload also performs a restart (see below).
- div_load with baud_sel=7 latches custom_div into the custom register and the active divisor, then restarts. With any other baud_sel, div_load updates only the custom register.
- The integer part is clamped to ≥2.
- Restart clears cnt, acc and os_phase. Causes are resync, a sel change, or a custom load.
- cnt counts from 0 to limit, where limit = int−1+carry. carry is the overflow of acc+frac, evaluated at the start of each period.
- At cnt==limit: os_tick=1, cnt←0, acc←acc+frac (mod 2^FRAC_W), os_phase advances modulo OVERSAMPLE.
- mid_tick = os_tick when os_phase==OVERSAMPLE/2−1.
- bit_tick = os_tick when os_phase==OVERSAMPLE−1.
- Priority: reset > restart > enable low > count. A restart cycle issues no tick even if cnt==limit.

## Timing
- Reset values: all outputs 0; cnt, acc and os_phase 0; active divisor and custom register hold the 9600 preset.
- Ticks are registered outputs. With int=N and frac=0, the first os_tick is asserted N cycles after reset release or restart, then every N cycles.
- Fractional mode: periods are int or int+1 cycles; over 2^FRAC_W ticks exactly frac of them are int+1.
- mid_tick and bit_tick coincide with os_tick in the same cycle. bit_tick falls on the cycle os_phase wraps to 0.
- enable low freezes cnt, acc and os_phase; counting resumes in place when enable returns high.
- A sel change takes effect with one cycle of latency: the change is detected, then the restart lands. The first tick at the new rate follows int_new cycles later.
- Simultaneous resync and div_load produce a single restart using the new divisor.

## Structure
- Package baud_pkg holds: the baud_sel enum (BAUD_2400 … BAUD_CUSTOM), the rate constants array, and the divisor function divisor(clk_hz, baud, os, frac_w). The function is shared with the Tx/Rx benches.
- One sub-module, frac_divider: cnt, acc and the limit logic, emitting raw os_tick.
- The top level holds sel tracking, divisor registers, the phase counter and the mid/bit decode.

## Test plan
- Reset, sel=2, CLK_HZ=50 MHz → os_tick periods alternate 325/326 cycles; 16 os_ticks take 5208 cycles; one bit_tick per 16 os_ticks.
- sel=7, custom_div={4,0} with div_load → os_tick every 4 cycles; mid_tick at os_phase 7; bit_tick at os_phase 15, every 64 cycles.
- custom {4,8} → period sequence 4,5,4,5…; int set to 1 → clamped, period 2.
- resync asserted mid-bit (os_phase=9) → no tick that cycle; os_phase=0; next os_tick exactly int cycles later.
- enable low for 100 cycles at os_phase 5 → no ticks; on resume, remaining cycles of the period complete and os_phase continues at 6.
- sel 2→6 mid-bit → restart one cycle after the change; periods settle to 27/28 pattern (2 of every 16 are 28); reset asserted mid-bit → all outputs 0 on the next edge.
